// File: rtl/l2_tcdm_bank_interleaver.sv
// Word-interleaved crossbar from TCDM masters onto L2 SRAM banks.
// Per-bank round-robin arbitration with 1-cycle response routing back to the winner.
module l2_tcdm_bank_interleaver #(
    parameter int NB_MASTERS = 4,
    parameter int NB_BANKS   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 36,
    parameter int BE_WIDTH   = 4
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic [NB_MASTERS-1:0]                 master_req_i,
    input  logic [NB_MASTERS-1:0][ADDR_WIDTH-1:0] master_add_i,
    input  logic [NB_MASTERS-1:0]                 master_wen_i,
    input  logic [NB_MASTERS-1:0][DATA_WIDTH-1:0] master_wdata_i,
    input  logic [NB_MASTERS-1:0][BE_WIDTH-1:0]   master_be_i,
    output logic [NB_MASTERS-1:0]                 master_gnt_o,
    output logic [NB_MASTERS-1:0]                 master_r_valid_o,
    output logic [NB_MASTERS-1:0][DATA_WIDTH-1:0] master_r_rdata_o,
    output logic [NB_BANKS-1:0]                   bank_req_o,
    output logic [NB_BANKS-1:0][ADDR_WIDTH-1:0]   bank_add_o,
    output logic [NB_BANKS-1:0]                   bank_wen_o,
    output logic [NB_BANKS-1:0][DATA_WIDTH-1:0]   bank_wdata_o,
    output logic [NB_BANKS-1:0][BE_WIDTH-1:0]     bank_be_o,
    input  logic [NB_BANKS-1:0]                   bank_gnt_i,
    input  logic [NB_BANKS-1:0]                   bank_r_valid_i,
    input  logic [NB_BANKS-1:0][DATA_WIDTH-1:0]   bank_r_rdata_i
);

    localparam int SelW = $clog2(NB_BANKS);
    localparam int IdxW = $clog2(NB_MASTERS);

    typedef logic [SelW-1:0] sel_t;
    typedef logic [IdxW-1:0] idx_t;

    sel_t [NB_MASTERS-1:0] sel;
    idx_t [NB_BANKS-1:0]   rr_q, rr_d;
    idx_t [NB_BANKS-1:0]   owner_q;
    idx_t [NB_BANKS-1:0]   win_idx;
    logic [NB_BANKS-1:0]   win_vld;
    logic [NB_BANKS-1:0]   pend_q, pend_d;

    always_comb begin
        for (int m = 0; m < NB_MASTERS; m++) begin
            sel[m] = master_add_i[m][2 +: SelW];
        end
    end

    // Search starts at the pointer and wraps, so the first hit is the winner.
    always_comb begin
        int   cand;
        idx_t ci;
        win_vld = '0;
        win_idx = '0;
        cand    = 0;
        ci      = '0;
        for (int b = 0; b < NB_BANKS; b++) begin
            for (int k = 0; k < NB_MASTERS; k++) begin
                cand = int'(rr_q[b]) + k;
                if (cand >= NB_MASTERS) begin
                    cand = cand - NB_MASTERS;
                end
                ci = idx_t'(cand);
                if (!win_vld[b] && master_req_i[ci] && sel[ci] == sel_t'(b)) begin
                    win_vld[b] = 1'b1;
                    win_idx[b] = ci;
                end
            end
        end
    end

    always_comb begin
        bank_req_o   = win_vld;
        bank_add_o   = '0;
        bank_wen_o   = '0;
        bank_wdata_o = '0;
        bank_be_o    = '0;
        for (int b = 0; b < NB_BANKS; b++) begin
            if (win_vld[b]) begin
                bank_add_o[b]   = master_add_i[win_idx[b]];
                bank_wen_o[b]   = master_wen_i[win_idx[b]];
                bank_wdata_o[b] = master_wdata_i[win_idx[b]];
                bank_be_o[b]    = master_be_i[win_idx[b]];
            end
        end
    end

    always_comb begin
        master_gnt_o = '0;
        for (int m = 0; m < NB_MASTERS; m++) begin
            master_gnt_o[m] = win_vld[sel[m]]
                            && (win_idx[sel[m]] == idx_t'(m))
                            && bank_gnt_i[sel[m]];
        end
    end

    always_comb begin
        rr_d   = rr_q;
        pend_d = '0;
        for (int b = 0; b < NB_BANKS; b++) begin
            pend_d[b] = bank_req_o[b] & bank_gnt_i[b];
            if (pend_d[b]) begin
                if (win_idx[b] == idx_t'(NB_MASTERS - 1)) begin
                    rr_d[b] = '0;
                end else begin
                    rr_d[b] = win_idx[b] + idx_t'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q    <= '0;
            pend_q  <= '0;
            owner_q <= '0;
        end else begin
            rr_q    <= rr_d;
            pend_q  <= pend_d;
            owner_q <= win_idx;
        end
    end

    always_comb begin
        master_r_valid_o = '0;
        master_r_rdata_o = '0;
        for (int m = 0; m < NB_MASTERS; m++) begin
            for (int b = 0; b < NB_BANKS; b++) begin
                if (pend_q[b] && bank_r_valid_i[b] && owner_q[b] == idx_t'(m)) begin
                    master_r_valid_o[m] = 1'b1;
                    master_r_rdata_o[m] = bank_r_rdata_i[b];
                end
            end
        end
    end

    // Responses without an outstanding grant are dropped by the routing above.
    always @(posedge clk_i) begin
        int hits;
        if (rst_ni) begin
            for (int b = 0; b < NB_BANKS; b++) begin
                assert (!(bank_r_valid_i[b] && !pend_q[b]))
                else $error("spurious bank response on bank %0d", b);
            end
            for (int m = 0; m < NB_MASTERS; m++) begin
                hits = 0;
                for (int b = 0; b < NB_BANKS; b++) begin
                    if (pend_q[b] && bank_r_valid_i[b] && owner_q[b] == idx_t'(m)) begin
                        hits++;
                    end
                end
                assert (hits <= 1)
                else $error("multiple responses to master %0d", m);
            end
        end
    end

endmodule
